// File: rtl/store_buffer_ctrl_pkg.sv
// Shared store-buffer types: store opcodes, the packed FIFO entry, and a lane-merge helper.
// Pure definitions with no timing or flow control of their own.
package store_buffer_ctrl_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } sb_entry_t;

  // Byte lanes enabled in be take the new data; the rest keep the old.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_dat,
                                              input logic [31:0] new_dat,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_dat[8*i +: 8] : old_dat[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_buffer_ctrl_st_lane_gen.sv
// Store decode: opcode + low address bits + rt value -> byte enables, lane-replicated data, error flag.
// Purely combinational; no flow control.
module st_lane_gen
  import store_buffer_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        bad
);

  always_comb begin
    be    = 4'b0000;
    wdata = data;
    bad   = 1'b1;
    case (op)
      OP_SW: begin
        be  = 4'b1111;
        bad = (addr_lo != 2'b00);
      end
      OP_SH: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
        bad   = addr_lo[0];
      end
      OP_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
        bad   = 1'b0;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Posted-write FIFO with tail coalescing and load-hazard CAM; drains to the data port when loads leave it idle.
// Store visible on mem_* one cycle after accept; st_ready drops when full or flushing, loads stall on hit/full/flush.
module store_buffer_ctrl
  import store_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     st_valid,
  input  logic [5:0]               st_op,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_ready,
  output logic                     st_err,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     ld_stall,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     mem_we,
  output logic [3:0]               mem_be,
  output logic [29:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  sb_entry_t        ent_q [DEPTH];
  sb_entry_t        ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_ptr;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic             st_err_q, st_err_d, flush_done_q, flush_done_d;

  logic [3:0]  new_be;
  logic [31:0] new_wdata;
  logic        new_bad;
  logic        full, hit, drain, accept, enq, coalesce, alloc;
  logic        unused_ld_lo;

  st_lane_gen u_lane_gen (
    .op      (st_op),
    .addr_lo (st_addr[1:0]),
    .data    (st_data),
    .be      (new_be),
    .wdata   (new_wdata),
    .bad     (new_bad)
  );

  assign unused_ld_lo = ^ld_addr[1:0];
  assign tail_ptr     = wr_ptr_q - PW'(1);
  assign full         = (count_q == CW'(DEPTH));

  // Port arbitration depends only on registered entries and ld_*.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && ent_q[i].waddr == ld_addr[31:2]) hit = 1'b1;
    end
    ld_stall  = ld_valid && (hit || full || state_q == S_FLUSH);
    drain     = (count_q != '0) && (!ld_valid || ld_stall);
    mem_we    = drain;
    mem_be    = drain ? ent_q[rd_ptr_q].be : 4'b0000;
    mem_addr  = ent_q[rd_ptr_q].waddr;
    mem_wdata = ent_q[rd_ptr_q].wdata;
  end

  assign st_ready   = !full && state_q == S_IDLE;
  assign st_err     = st_err_q;
  assign flush_done = flush_done_q;
  assign count      = count_q;

  always_comb begin
    ent_d    = ent_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    accept   = st_valid && st_ready;
    enq      = accept && !new_bad;
    // A lone tail that is draining this cycle cannot absorb the store.
    coalesce = enq && count_q != '0 && ent_q[tail_ptr].waddr == st_addr[31:2]
               && !(drain && count_q == CW'(1));
    alloc    = enq && !coalesce;
    st_err_d = accept && new_bad;

    if (drain) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (coalesce) begin
      ent_d[tail_ptr].be    = ent_q[tail_ptr].be | new_be;
      ent_d[tail_ptr].wdata = merge_lanes(ent_q[tail_ptr].wdata, new_wdata, new_be);
    end else if (alloc) begin
      ent_d[wr_ptr_q] = '{waddr: st_addr[31:2], be: new_be, wdata: new_wdata};
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(alloc) - CW'(drain);

    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          if (count_q == '0) flush_done_d = 1'b1;
          else               state_d      = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (count_d == '0) begin
          state_d      = S_IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      vld_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      st_err_q     <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      ent_q        <= ent_d;
      vld_q        <= vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      st_err_q     <= st_err_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed bench for store_buffer_ctrl: queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_store_buffer_ctrl;

  localparam int DEPTH = 4;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SB = 6'b101000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        st_valid = 1'b0;
  logic [5:0]  st_op = '0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        flush_req = 1'b0;
  logic        st_ready, st_err, ld_stall, flush_done, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [$clog2(DEPTH):0] count;

  store_buffer_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_flush = 0;
  bit   m_err = 0;
  bit   m_done = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: outputs from the pending-store queue, then advance it by one clock.
  task automatic model_cycle();
    int          n;
    bit          full, hz, e_rdy, e_stall, e_we, ok, acc, merge;
    logic [3:0]  nb;
    logic [31:0] nd;
    ent_t        t;
    if (!rstn) begin
      mq.delete();
      m_flush = 0;
      m_err   = 0;
      m_done  = 0;
    end
    n  = mq.size();
    full = (n == DEPTH);
    hz = 0;
    foreach (mq[i]) if (ld_valid && mq[i].wa == ld_addr[31:2]) hz = 1;
    e_rdy   = !full && !m_flush;
    e_stall = ld_valid && (hz || full || m_flush);
    e_we    = (n > 0) && (!ld_valid || e_stall);
    chk("count", 32'(count), 32'(n));
    chk("st_ready", 32'(st_ready), 32'(e_rdy));
    chk("st_err", 32'(st_err), 32'(m_err));
    chk("flush_done", 32'(flush_done), 32'(m_done));
    chk("ld_stall", 32'(ld_stall), 32'(e_stall));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_be", 32'(mem_be), e_we ? 32'(mq[0].be) : 32'h0);
    if (e_we) begin
      chk("mem_addr", 32'(mem_addr), 32'(mq[0].wa));
      chk("mem_wdata", mem_wdata, mq[0].d);
    end
    if (!rstn) return;

    ok = 0; nb = 4'h0; nd = st_data;
    case (st_op)
      SW: begin ok = (st_addr[1:0] == 2'b00); nb = 4'hF; nd = st_data; end
      SH: begin ok = !st_addr[0]; nb = st_addr[1] ? 4'hC : 4'h3; nd = {2{st_data[15:0]}}; end
      SB: begin ok = 1; nb = 4'b0001 << st_addr[1:0]; nd = {4{st_data[7:0]}}; end
      default: ok = 0;
    endcase
    acc   = st_valid && e_rdy;
    merge = acc && ok && n > 0 && mq[n-1].wa == st_addr[31:2] && !(e_we && n == 1);
    if (e_we) void'(mq.pop_front());
    if (acc && ok) begin
      if (merge) begin
        t = mq[mq.size()-1];
        for (int b = 0; b < 4; b++) if (nb[b]) t.d[8*b +: 8] = nd[8*b +: 8];
        t.be = t.be | nb;
        mq[mq.size()-1] = t;
      end else begin
        t.wa = st_addr[31:2]; t.be = nb; t.d = nd;
        mq.push_back(t);
      end
    end
    m_err  = acc && !ok;
    m_done = 0;
    if (!m_flush) begin
      if (flush_req) begin
        if (n == 0) m_done = 1;
        else        m_flush = 1;
      end
    end else if (mq.size() == 0) begin
      m_flush = 0;
      m_done  = 1;
    end
  endtask

  always @(negedge clk) begin
    #4;
    model_cycle();
  end

  task automatic drv(input bit sv, input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                     input bit lv, input logic [31:0] la, input bit fr);
    @(negedge clk);
    st_valid = sv; st_op = op; st_addr = a; st_data = d;
    ld_valid = lv; ld_addr = la; flush_req = fr;
    #2;
  endtask

  task automatic idle(input bit lv, input logic [31:0] la);
    drv(0, 6'h0, 32'h0, 32'h0, lv, la, 0);
  endtask

  initial begin
    int writes, dones;
    bit got;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_st_ready", 32'(st_ready), 32'h1);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // SB to 0x103 drains next cycle on an idle port
    drv(1, SB, 32'h103, 32'hAB, 0, 32'h0, 0);
    chk("sb_not_yet_visible", 32'(mem_we), 32'h0);
    idle(0, 32'h0);
    chk("sb_we", 32'(mem_we), 32'h1);
    chk("sb_addr", 32'(mem_addr), 32'h40);
    chk("sb_be", 32'(mem_be), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    idle(0, 32'h0);
    chk("sb_count0", 32'(count), 32'h0);

    // SH then SB to the same word coalesce while loads own the port
    drv(1, SH, 32'h200, 32'h1234, 1, 32'h800, 0);
    drv(1, SB, 32'h201, 32'h56, 1, 32'h800, 0);
    idle(1, 32'h800);
    chk("co_count", 32'(count), 32'h1);
    chk("co_model_size", 32'(mq.size()), 32'h1);
    chk("co_model_be", 32'(mq[0].be), 32'h3);
    chk("co_model_lo", 32'(mq[0].d[15:0]), 32'h5634);
    idle(0, 32'h0);
    chk("co_be", 32'(mem_be), 32'h3);
    chk("co_wdata", mem_wdata, 32'h12345634);
    idle(0, 32'h0);

    // Fill with continuous loads; full stalls, refuses the store, drains one
    for (int i = 0; i < 4; i++) drv(1, SW, 32'h400 + 32'(4*i), 32'(i+1), 1, 32'h900, 0);
    drv(1, SW, 32'h410, 32'h55, 1, 32'h900, 0);
    chk("full_count", 32'(count), 32'h4);
    chk("full_st_ready", 32'(st_ready), 32'h0);
    chk("full_stall", 32'(ld_stall), 32'h1);
    chk("full_addr", 32'(mem_addr), 32'h100);
    idle(1, 32'h900);
    chk("after_pop_count", 32'(count), 32'h3);
    chk("after_pop_ready", 32'(st_ready), 32'h1);
    chk("after_pop_stall", 32'(ld_stall), 32'h0);
    drv(1, SW, 32'h414, 32'h77, 0, 32'h0, 0);
    idle(0, 32'h0);
    chk("enq_pop_count", 32'(count), 32'h3);
    chk("enq_pop_addr", 32'(mem_addr), 32'h102);
    repeat (2) idle(0, 32'h0);
    idle(0, 32'h0);
    chk("fill_drained", 32'(count), 32'h0);

    // Load hazard against a pending word
    drv(1, SW, 32'h300, 32'hDEADBEEF, 1, 32'h900, 0);
    idle(1, 32'h302);
    chk("hz_stall", 32'(ld_stall), 32'h1);
    chk("hz_addr", 32'(mem_addr), 32'hC0);
    chk("hz_wdata", mem_wdata, 32'hDEADBEEF);
    idle(1, 32'h302);
    chk("hz_release", 32'(ld_stall), 32'h0);

    // Misaligned SW and non-store opcode
    drv(1, SW, 32'h102, 32'h1, 0, 32'h0, 0);
    drv(1, 6'b100011, 32'h100, 32'h2, 0, 32'h0, 0);
    chk("err1", 32'(st_err), 32'h1);
    idle(0, 32'h0);
    chk("err2", 32'(st_err), 32'h1);
    chk("err_count", 32'(count), 32'h0);
    idle(0, 32'h0);
    chk("err_clear", 32'(st_err), 32'h0);

    // Flush with loads held: three writes, one done pulse
    for (int i = 0; i < 3; i++) drv(1, SW, 32'h500 + 32'(4*i), 32'hA0 + 32'(i), 1, 32'h900, 0);
    writes = 0; dones = 0; got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      drv(0, 6'h0, 32'h0, 32'h0, 1, 32'h900, 1);
      if (mem_we) writes++;
      if (flush_done) begin
        dones++;
        got = 1;
        flush_req = 1'b0;
      end
    end
    chk("flush_seen", 32'(got), 32'h1);
    for (int k = 0; k < 3; k++) begin
      idle(1, 32'h900);
      if (flush_done) dones++;
    end
    chk("flush_writes", 32'(writes), 32'h3);
    chk("flush_dones", 32'(dones), 32'h1);
    chk("flush_idle_ready", 32'(st_ready), 32'h1);

    // Reset in the middle of a second flush discards pending stores
    drv(1, SW, 32'h600, 32'h6, 1, 32'h900, 0);
    drv(1, SW, 32'h604, 32'h7, 1, 32'h900, 0);
    drv(0, 6'h0, 32'h0, 32'h0, 1, 32'h900, 1);
    drv(0, 6'h0, 32'h0, 32'h0, 1, 32'h900, 1);
    chk("fl2_stall", 32'(ld_stall), 32'h1);
    chk("fl2_we", 32'(mem_we), 32'h1);
    @(negedge clk);
    rstn = 1'b0; flush_req = 1'b0;
    #2;
    chk("mr_count", 32'(count), 32'h0);
    chk("mr_ready", 32'(st_ready), 32'h1);
    chk("mr_stall", 32'(ld_stall), 32'h0);
    chk("mr_we", 32'(mem_we), 32'h0);
    chk("mr_be", 32'(mem_be), 32'h0);
    chk("mr_done", 32'(flush_done), 32'h0);
    chk("mr_err", 32'(st_err), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    idle(0, 32'h0);
    chk("post_rst_we", 32'(mem_we), 32'h0);
    idle(0, 32'h0);
    chk("post_rst_count", 32'(count), 32'h0);

    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
